// File: rtl/dsp_trig_avg.sv
`timescale 1ns/1ps
// Triggered capture of CH serial ADC channels, averaged over 2^AVG_LOG2 conversions
// and presented on a valid/ready output with sticky missed/overrun flags.
module dsp_trig_avg #(
    parameter int unsigned CH       = 4,
    parameter int unsigned DATLEN   = 12,
    parameter int unsigned DELAY    = 100,
    parameter int unsigned AVG_LOG2 = 6
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 trigger,
    input  logic [CH-1:0]        sdata,
    output logic [CH*DATLEN-1:0] avg,
    output logic                 avg_valid,
    input  logic                 avg_ready,
    output logic                 missed,
    output logic                 overrun
);

    localparam int unsigned ACC_W = DATLEN + AVG_LOG2;
    localparam int unsigned DLY_W = $clog2(DELAY + 1);
    localparam int unsigned BIT_W = $clog2(DATLEN + 1);
    localparam int unsigned CNT_W = AVG_LOG2 + 1;
    localparam int unsigned N     = 2 ** AVG_LOG2;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_SHIFT,
        ST_ACCUM
    } state_t;

    state_t               r_state;
    state_t               w_next;
    logic                 r_trig;
    logic                 w_edge;
    logic [DLY_W-1:0]     r_dly;
    logic [BIT_W-1:0]     r_bit;
    logic [CNT_W-1:0]     r_cnt;
    logic [DATLEN-1:0]    r_shift [CH];
    logic [ACC_W-1:0]     r_acc   [CH];
    logic [ACC_W-1:0]     w_sum   [CH];
    logic [DATLEN-1:0]    w_res   [CH];
    logic [CH*DATLEN-1:0] r_avg;
    logic                 r_valid;
    logic                 r_missed;
    logic                 r_overrun;
    logic                 w_dly_done;
    logic                 w_bit_done;
    logic                 w_form;

    assign w_edge     = trigger & ~r_trig;
    assign w_dly_done = (r_dly == DLY_W'(DELAY - 1));
    assign w_bit_done = (r_bit == BIT_W'(DATLEN - 1));
    assign w_form     = (r_state == ST_ACCUM) && (r_cnt == CNT_W'(N - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:  if (w_edge) w_next = ST_WAIT;
            ST_WAIT:  if (w_dly_done) w_next = ST_SHIFT;
            ST_SHIFT: if (w_bit_done) w_next = ST_ACCUM;
            ST_ACCUM: w_next = ST_IDLE;
            default:  w_next = ST_IDLE;
        endcase
    end

    // Trigger history and the WAIT / SHIFT cycle counters
    always_ff @(posedge clk) begin
        if (rst) begin
            r_trig <= 1'b0;
            r_dly  <= '0;
            r_bit  <= '0;
        end else begin
            r_trig <= trigger;
            r_dly  <= (r_state == ST_WAIT && !w_dly_done) ? r_dly + DLY_W'(1) : '0;
            r_bit  <= (r_state == ST_SHIFT && !w_bit_done) ? r_bit + BIT_W'(1) : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned c = 0; c < CH; c++) begin
                r_shift[c] <= '0;
            end
        end else if (r_state == ST_SHIFT) begin
            for (int unsigned c = 0; c < CH; c++) begin
                r_shift[c] <= DATLEN'({r_shift[c], sdata[c]});
            end
        end
    end

    always_comb begin
        for (int unsigned c = 0; c < CH; c++) begin
            w_sum[c] = r_acc[c] + ACC_W'(r_shift[c]);
            w_res[c] = DATLEN'(w_sum[c] >> AVG_LOG2);
        end
    end

    // Accumulators restart from zero in the same cycle a result is formed
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
            for (int unsigned c = 0; c < CH; c++) begin
                r_acc[c] <= '0;
            end
        end else if (r_state == ST_ACCUM) begin
            if (w_form) begin
                r_cnt <= '0;
                for (int unsigned c = 0; c < CH; c++) begin
                    r_acc[c] <= '0;
                end
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
                for (int unsigned c = 0; c < CH; c++) begin
                    r_acc[c] <= w_sum[c];
                end
            end
        end
    end

    // Output slot: a held, unconsumed result wins over a newly formed one
    always_ff @(posedge clk) begin
        if (rst) begin
            r_avg     <= '0;
            r_valid   <= 1'b0;
            r_missed  <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            if (w_form) begin
                if (!r_valid || avg_ready) begin
                    for (int unsigned c = 0; c < CH; c++) begin
                        r_avg[c*DATLEN +: DATLEN] <= w_res[c];
                    end
                    r_valid <= 1'b1;
                end else begin
                    r_overrun <= 1'b1;
                end
            end else if (r_valid && avg_ready) begin
                r_valid <= 1'b0;
            end
            if (w_edge && r_state != ST_IDLE) begin
                r_missed <= 1'b1;
            end
        end
    end

    assign avg       = r_avg;
    assign avg_valid = r_valid;
    assign missed    = r_missed;
    assign overrun   = r_overrun;

endmodule
